// File: rtl/plot_arbiter.sv
// Three-way round-robin arbiter that forwards one granted requester's pixel
// stream to the VGA adapter with a single registered stage and a per-grant timeout.
module plot_arbiter #(
  parameter int TIMEOUT = 19200
) (
  input  logic       clk,
  input  logic       stateReset,
  input  logic [2:0] req,
  input  logic [2:0] vld,
  input  logic [2:0] last,
  input  logic [7:0] x0,
  input  logic [7:0] x1,
  input  logic [7:0] x2,
  input  logic [6:0] y0,
  input  logic [6:0] y1,
  input  logic [6:0] y2,
  input  logic [2:0] c0,
  input  logic [2:0] c1,
  input  logic [2:0] c2,
  output logic [2:0] gnt,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] color,
  output logic       plot,
  output logic       busy,
  output logic       timeoutErr
);

  // Handshake: a pixel transfers in a cycle where gnt[i] && vld[i]; it appears
  // on x/y/color with plot=1 exactly one cycle later. There is no backpressure.

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [14:0] TMO_LAST = 15'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [2:0]  gnt_next;
  logic [1:0]  last_served, last_served_next;
  logic [14:0] cnt, cnt_next;
  logic        err_next;
  logic        acc, acc_last, still_req, tmo;
  logic [1:0]  pick_idx;
  logic [7:0]  px_x;
  logic [6:0]  px_y;
  logic [2:0]  px_c;

  // Scanning from farthest to nearest lets the nearest requester win.
  function automatic logic [1:0] pick(input logic [1:0] ls, input logic [2:0] r);
    int i;
    pick = ls;
    for (int k = 3; k >= 1; k--) begin
      i = (int'(ls) + k) % 3;
      if (r[i]) pick = 2'(i);
    end
  endfunction

  assign busy      = (state == GRANT);
  assign acc       = |(gnt & vld);
  assign acc_last  = |(gnt & vld & last);
  assign still_req = |(gnt & req);
  assign tmo       = (cnt == TMO_LAST);
  assign pick_idx  = pick(last_served, req);

  always_comb begin
    px_x = '0;
    px_y = '0;
    px_c = '0;
    unique case (gnt)
      3'b001:  begin px_x = x0; px_y = y0; px_c = c0; end
      3'b010:  begin px_x = x1; px_y = y1; px_c = c1; end
      3'b100:  begin px_x = x2; px_y = y2; px_c = c2; end
      default: ;
    endcase
  end

  always_comb begin
    state_next       = state;
    gnt_next         = gnt;
    last_served_next = last_served;
    cnt_next         = cnt;
    err_next         = timeoutErr;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_next       = GRANT;
          gnt_next         = 3'b001 << pick_idx;
          last_served_next = pick_idx;
          cnt_next         = '0;
        end
      end
      GRANT: begin
        cnt_next = (cnt == '1) ? cnt : cnt + 15'd1;
        // A last pixel wins over a coincident timeout, so no error then.
        if (acc_last || !still_req || tmo) begin
          state_next = IDLE;
          gnt_next   = '0;
          if (!acc_last && tmo) err_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (stateReset) begin
      state       <= IDLE;
      gnt         <= '0;
      last_served <= 2'd2;
      cnt         <= '0;
      timeoutErr  <= 1'b0;
      plot        <= 1'b0;
      x           <= '0;
      y           <= '0;
      color       <= '0;
    end else begin
      state       <= state_next;
      gnt         <= gnt_next;
      last_served <= last_served_next;
      cnt         <= cnt_next;
      timeoutErr  <= err_next;
      plot        <= acc;
      if (acc) begin
        x     <= px_x;
        y     <= px_y;
        color <= px_c;
      end
    end
  end

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter: arbitration order, pixel forwarding,
// timeout, abort and mid-grant reset, with hand-computed expectations.
module tb_plot_arbiter;

  logic       clk = 1'b0;
  logic       stateReset;
  logic [2:0] req, vld, last;
  logic [7:0] x0, x1, x2;
  logic [6:0] y0, y1, y2;
  logic [2:0] c0, c1, c2;
  logic [2:0] gnt;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] color;
  logic       plot, busy, timeoutErr;

  int n_tests = 0;
  int n_fail  = 0;

  plot_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .stateReset(stateReset), .req(req), .vld(vld), .last(last),
    .x0(x0), .x1(x1), .x2(x2), .y0(y0), .y1(y1), .y2(y2),
    .c0(c0), .c1(c1), .c2(c2),
    .gnt(gnt), .x(x), .y(y), .color(color), .plot(plot),
    .busy(busy), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  // One clock edge, then settle so inputs change and outputs are sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pix(input string tag, input logic p, input logic [7:0] ex,
                           input logic [6:0] ey, input logic [2:0] ec);
    check_eq({tag, " plot"}, 32'(plot), 32'(p));
    check_eq({tag, " x"}, 32'(x), 32'(ex));
    check_eq({tag, " y"}, 32'(y), 32'(ey));
    check_eq({tag, " color"}, 32'(color), 32'(ec));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stateReset = 1'b1;
    req = '0; vld = '0; last = '0;
    x0 = '0; x1 = '0; x2 = '0; y0 = '0; y1 = '0; y2 = '0;
    c0 = '0; c1 = '0; c2 = '0;
    step();
    step();
    stateReset = 1'b0;
    check_eq("rst gnt", 32'(gnt), 0);
    check_eq("rst busy", 32'(busy), 0);
    check_eq("rst err", 32'(timeoutErr), 0);
    check_pix("rst", 1'b0, 8'd0, 7'd0, 3'd0);

    // Round robin from reset: requester 0 first.
    req = 3'b111;
    step();
    check_eq("rr gnt0", 32'(gnt), 32'b001);
    check_eq("rr busy0", 32'(busy), 1);
    vld = 3'b001; last = 3'b001; x0 = 8'd1; y0 = 7'd2; c0 = 3'd3;
    step();
    check_eq("rr gap0", 32'(gnt), 0);
    check_eq("rr busy gap0", 32'(busy), 0);
    check_pix("rr last0", 1'b1, 8'd1, 7'd2, 3'd3);
    vld = '0; last = '0;
    step();
    check_eq("rr gnt1", 32'(gnt), 32'b010);
    check_eq("rr plot idle", 32'(plot), 0);

    // Requester 1 streams four pixels, last on the fourth.
    for (int k = 0; k < 4; k++) begin
      vld = 3'b010; last = (k == 3) ? 3'b010 : 3'b000;
      x1 = 8'(10 + k); y1 = 7'd20; c1 = 3'd5;
      step();
      check_pix($sformatf("burst%0d", k), 1'b1, 8'(10 + k), 7'd20, 3'd5);
      check_eq($sformatf("burst%0d gnt", k), 32'(gnt), (k == 3) ? 0 : 32'b010);
    end
    vld = '0; last = '0;
    step();
    check_eq("rr gnt2", 32'(gnt), 32'b100);
    check_pix("hold", 1'b0, 8'd13, 7'd20, 3'd5);
    vld = 3'b100; last = 3'b100; x2 = 8'd50; y2 = 7'd60; c2 = 3'd2;
    req = '0;
    step();
    check_eq("rr end2", 32'(gnt), 0);
    check_pix("last2", 1'b1, 8'd50, 7'd60, 3'd2);
    vld = '0; last = '0;
    step();
    check_eq("idle no req", 32'(gnt), 0);
    check_eq("idle busy", 32'(busy), 0);

    // Requester 0 granted; vld toggles while ungranted requester 2 drives data.
    req = 3'b101;
    step();
    check_eq("tog gnt", 32'(gnt), 32'b001);
    x2 = 8'd99; y2 = 7'd99; c2 = 3'd7;
    vld = 3'b101; x0 = 8'd30; y0 = 7'd40; c0 = 3'd1;
    step();
    check_pix("tog a", 1'b1, 8'd30, 7'd40, 3'd1);
    vld = 3'b100;
    step();
    check_pix("tog b", 1'b0, 8'd30, 7'd40, 3'd1);
    check_eq("tog b gnt", 32'(gnt), 32'b001);
    vld = 3'b101; last = 3'b001; x0 = 8'd31;
    step();
    check_pix("tog c", 1'b1, 8'd31, 7'd40, 3'd1);
    check_eq("tog end", 32'(gnt), 0);
    req = '0; vld = '0; last = '0;
    step();
    check_eq("tog idle plot", 32'(plot), 0);

    // Timeout: requester 2 holds the grant for 8 cycles with no last.
    req = 3'b100;
    step();
    check_eq("tmo gnt", 32'(gnt), 32'b100);
    for (int i = 1; i < 8; i++) begin
      step();
      check_eq($sformatf("tmo hold%0d", i), 32'(gnt), 32'b100);
    end
    check_eq("tmo err pre", 32'(timeoutErr), 0);
    vld = 3'b100; x2 = 8'd77; y2 = 7'd11; c2 = 3'd4;
    step();
    check_eq("tmo end", 32'(gnt), 0);
    check_eq("tmo err", 32'(timeoutErr), 1);
    check_eq("tmo busy", 32'(busy), 0);
    check_pix("tmo pix", 1'b1, 8'd77, 7'd11, 3'd4);
    req = '0; vld = '0;
    step();

    // Abort: requester 1 drops req alongside its second pixel.
    req = 3'b010;
    step();
    check_eq("ab gnt", 32'(gnt), 32'b010);
    vld = 3'b010; x1 = 8'd60; y1 = 7'd1; c1 = 3'd6;
    step();
    check_pix("ab p1", 1'b1, 8'd60, 7'd1, 3'd6);
    req = '0; x1 = 8'd61;
    step();
    check_pix("ab p2", 1'b1, 8'd61, 7'd1, 3'd6);
    check_eq("ab end", 32'(gnt), 0);
    check_eq("ab err sticky", 32'(timeoutErr), 1);
    vld = '0; req = 3'b111;
    step();
    check_eq("ab next", 32'(gnt), 32'b100);

    // Reset mid-grant with a pixel offered.
    vld = 3'b100; x2 = 8'd5; y2 = 7'd5; c2 = 3'd5; stateReset = 1'b1;
    step();
    check_eq("mrst gnt", 32'(gnt), 0);
    check_eq("mrst err", 32'(timeoutErr), 0);
    check_eq("mrst busy", 32'(busy), 0);
    check_pix("mrst", 1'b0, 8'd0, 7'd0, 3'd0);
    stateReset = 1'b0; vld = '0;
    step();
    check_eq("mrst regrant", 32'(gnt), 32'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
